serial_tx_scheduler: RTL and testbench

SERIAL_TX_SCHEDULER -- requirements
Module: serial_tx_scheduler

---
 rtl/serial_tx_scheduler.sv | 111 +++++++++++
 tb/tb_serial_tx_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_scheduler.sv
// Round-robin scheduler that accepts one wide word from one of NREQ requesters
// and streams it out LSB beat first, OUTWIDTH bits per accepted beat.
module serial_tx_scheduler #(
  parameter int NREQ     = 2,
  parameter int INWIDTH  = 256,
  parameter int OUTWIDTH = 8,
  localparam int NB = INWIDTH / OUTWIDTH,
  localparam int LW = $clog2(NB) + 1,
  localparam int SW = (NREQ > 2) ? $clog2(NREQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*INWIDTH-1:0]  req_data,
  input  logic [NREQ*LW-1:0]       req_len,
  output logic [NREQ-1:0]          req_ready,
  output logic [OUTWIDTH-1:0]      out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [SW-1:0]            out_src,
  output logic                     busy
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             r_state;
  logic [INWIDTH-1:0] r_shift;
  logic [LW-1:0]      r_cnt;
  logic [SW-1:0]      r_src;
  logic [SW-1:0]      r_last_grant;

  logic [NREQ-1:0]    w_grant;
  logic [SW-1:0]      w_win;
  logic [SW-1:0]      w_idx;
  logic               w_any;
  logic [INWIDTH-1:0] w_data;
  logic [LW-1:0]      w_len;
  logic [LW-1:0]      w_len_clamp;

  // Walk the requesters starting just after the last grant, wrapping at NREQ.
  always_comb begin
    w_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    w_idx   = r_last_grant;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = (w_idx == SW'(NREQ - 1)) ? '0 : w_idx + SW'(1);
      if (!w_any && req_valid[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (w_any) w_grant[w_win] = 1'b1;
  end

  always_comb begin
    w_data = '0;
    w_len  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_data = req_data[i*INWIDTH +: INWIDTH];
        w_len  = req_len[i*LW +: LW];
      end
    end
  end

  assign w_len_clamp = (w_len > LW'(NB)) ? LW'(NB) : w_len;

  assign req_ready = (reset && r_state == IDLE) ? w_grant : '0;
  assign out_valid = (r_state == SEND);
  assign busy      = (r_state == SEND);
  assign out_last  = (r_state == SEND) && (r_cnt == LW'(1));
  assign out_data  = r_shift[OUTWIDTH-1:0];
  assign out_src   = r_src;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_src        <= '0;
      r_last_grant <= SW'(NREQ - 1);
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_last_grant <= w_win;
            // Zero-length words are granted but produce no message.
            if (w_len_clamp != '0) begin
              r_shift <= w_data;
              r_cnt   <= w_len_clamp;
              r_src   <= w_win;
              r_state <= SEND;
            end
          end
        end
        SEND: begin
          if (out_ready) begin
            r_cnt <= r_cnt - LW'(1);
            // The final beat is left in place so out_data holds it while idle.
            if (r_cnt == LW'(1)) r_state <= IDLE;
            else                 r_shift <= r_shift >> OUTWIDTH;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: directed scenarios plus a randomized run
// checked against a message-level scoreboard model.
module tb_serial_tx_scheduler;

  localparam int NREQ = 2;
  localparam int INW  = 256;
  localparam int OUTW = 8;
  localparam int NB   = INW / OUTW;
  localparam int LW   = $clog2(NB) + 1;
  localparam int SW   = 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*INW-1:0]  req_data;
  logic [NREQ*LW-1:0]   req_len;
  logic [NREQ-1:0]      req_ready;
  logic [OUTW-1:0]      out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic [SW-1:0]        out_src;
  logic                 busy;

  int n_cmp  = 0;
  int n_fail = 0;

  serial_tx_scheduler #(.NREQ(NREQ), .INWIDTH(INW), .OUTWIDTH(OUTW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_len(req_len), .req_ready(req_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_src(out_src), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [OUTW-1:0] d;
    logic            l;
    logic [SW-1:0]   s;
  } beat_t;

  beat_t m_q[$];
  int    m_lg;
  bit    m_busy;

  task automatic set_req(input int i, input logic v, input logic [INW-1:0] d, input int len);
    req_valid[i]          = v;
    req_data[i*INW +: INW] = d;
    req_len[i*LW +: LW]    = LW'(len);
  endtask

  task automatic model_reset();
    m_q.delete();
    m_lg   = NREQ - 1;
    m_busy = 0;
  endtask

  function automatic int model_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_lg + k) % NREQ;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  // One clock's worth of behaviour: a message is a list of beats, drained by out_ready.
  task automatic model_step();
    if (m_busy) begin
      if (out_ready) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 0;
      end
    end else begin
      int w;
      w = model_winner();
      if (w >= 0) begin
        int len;
        m_lg = w;
        len  = int'(req_len[w*LW +: LW]);
        if (len > NB) len = NB;
        for (int k = 0; k < len; k++) begin
          beat_t b;
          b.d = req_data[w*INW + k*OUTW +: OUTW];
          b.l = (k == len - 1);
          b.s = SW'(w);
          m_q.push_back(b);
        end
        if (len > 0) m_busy = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_len   = '0;
    set_req(0, 1'b1, 256'h04030201, 4);
    set_req(1, 1'b1, 256'h0a0b, 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b expected 0", out_last); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", out_data); end
    n_cmp++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL reset_src: got %0d expected 0", out_src); end
    @(posedge clk); #1;
    req_valid = '0;
    reset     = 1'b1;
  endtask

  task automatic test_single();
    set_req(0, 1'b1, 256'h04030201, 4);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_prevalid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++; if (out_data !== 8'(k + 1)) begin n_fail++; $display("FAIL single_data[%0d]: got %h expected %h", k, out_data, 8'(k + 1)); end
      n_cmp++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL single_last[%0d]: got %b expected %b", k, out_last, (k == 3)); end
      n_cmp++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL single_src[%0d]: got %0d expected 0", k, out_src); end
      n_cmp++; if (req_ready !== 2'b00) begin n_fail++; $display("FAIL single_busyready[%0d]: got %b expected 00", k, req_ready); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_endvalid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_endbusy: got %b expected 0", busy); end
    n_cmp++; if (out_data !== 8'h04) begin n_fail++; $display("FAIL single_holddata: got %h expected 04", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    set_req(0, 1'b1, 256'h04030201, 4);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      int stall;
      stall = (k == 1) ? 3 : 0;
      for (int s = 0; s <= stall; s++) begin
        out_ready = (s == stall);
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d.%0d]: got %b expected 1", k, s, out_valid); end
        n_cmp++; if (out_data !== 8'(k + 1)) begin n_fail++; $display("FAIL bp_data[%0d.%0d]: got %h expected %h", k, s, out_data, 8'(k + 1)); end
        n_cmp++; if (out_last !== (k == 3)) begin n_fail++; $display("FAIL bp_last[%0d.%0d]: got %b expected %b", k, s, out_last, (k == 3)); end
        n_cmp++; if (out_src !== 1'b0) begin n_fail++; $display("FAIL bp_src[%0d.%0d]: got %0d expected 0", k, s, out_src); end
        @(posedge clk); #1;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_endvalid: got %b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, 1'b1, {240'b0, 8'hB0, 8'hA0}, 2);
    set_req(1, 1'b1, {240'b0, 8'hB1, 8'hA1}, 2);
    for (int m = 0; m < 4; m++) begin
      int src;
      src = m % 2;
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'(1 << src)) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b expected %b", m, req_ready, 2'(1 << src)); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rr_bubble[%0d]: got %b expected 0", m, out_valid); end
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d.%0d]: got %b expected 1", m, k, out_valid); end
        n_cmp++; if (out_data !== 8'((k ? 8'hB0 : 8'hA0) + src)) begin n_fail++; $display("FAIL rr_data[%0d.%0d]: got %h expected %h", m, k, out_data, 8'((k ? 8'hB0 : 8'hA0) + src)); end
        n_cmp++; if (out_src !== SW'(src)) begin n_fail++; $display("FAIL rr_src[%0d.%0d]: got %0d expected %0d", m, k, out_src, src); end
        n_cmp++; if (out_last !== (k == 1)) begin n_fail++; $display("FAIL rr_last[%0d.%0d]: got %b expected %b", m, k, out_last, (k == 1)); end
        @(posedge clk); #1;
      end
    end
    req_valid = '0;
  endtask

  task automatic test_len_boundary();
    logic [INW-1:0] big;
    for (int w = 0; w < INW / 32; w++) big[w*32 +: 32] = $urandom();
    set_req(0, 1'b1, 256'h55, 0);
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL len0_ready: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    set_req(1, 1'b1, 256'h66, 0);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_novalid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL len0_busy: got %b expected 0", busy); end
    n_cmp++; if (req_ready !== 2'b10) begin n_fail++; $display("FAIL len0_advance: got %b expected 10", req_ready); end
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    set_req(0, 1'b1, big, 63);
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len0_novalid2: got %b expected 0", out_valid); end
    n_cmp++; if (req_ready !== 2'b01) begin n_fail++; $display("FAIL len63_ready: got %b expected 01", req_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL len63_valid[%0d]: got %b expected 1", k, out_valid); end
      n_cmp++; if (out_data !== big[k*OUTW +: OUTW]) begin n_fail++; $display("FAIL len63_data[%0d]: got %h expected %h", k, out_data, big[k*OUTW +: OUTW]); end
      n_cmp++; if (out_last !== (k == NB - 1)) begin n_fail++; $display("FAIL len63_last[%0d]: got %b expected %b", k, out_last, (k == NB - 1)); end
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL len63_end: got %b expected 0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    set_req(0, 1'b1, 256'h04030201, 4);
    @(posedge clk); #1;
    req_valid = '0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_cmp++; if (out_data !== 8'(k + 1)) begin n_fail++; $display("FAIL rstmid_data[%0d]: got %h expected %h", k, out_data, 8'(k + 1)); end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_residual[%0d]: got %b expected 0", c, out_valid); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    req_valid = '0;
    reset     = 1'b0;
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 800; c++) begin
      logic [NREQ-1:0] exp_ready;
      int w;
      for (int i = 0; i < NREQ; i++) begin
        int r;
        int len;
        logic [INW-1:0] d;
        for (int x = 0; x < INW / 32; x++) d[x*32 +: 32] = $urandom();
        r = $urandom_range(0, 9);
        len = (r == 0) ? 0 : (r == 1) ? $urandom_range(33, 63) : $urandom_range(1, 5);
        set_req(i, ($urandom_range(0, 3) != 0), d, len);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      w = model_winner();
      exp_ready = (!m_busy && w >= 0) ? NREQ'(1 << w) : '0;
      n_cmp++; if (req_ready !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", c, req_ready, exp_ready); end
      n_cmp++; if (out_valid !== m_busy) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, out_valid, m_busy); end
      n_cmp++; if (busy !== m_busy) begin n_fail++; $display("FAIL rand_busy[%0d]: got %b expected %b", c, busy, m_busy); end
      if (m_busy) begin
        n_cmp++; if (out_data !== m_q[0].d) begin n_fail++; $display("FAIL rand_data[%0d]: got %h expected %h", c, out_data, m_q[0].d); end
        n_cmp++; if (out_last !== m_q[0].l) begin n_fail++; $display("FAIL rand_last[%0d]: got %b expected %b", c, out_last, m_q[0].l); end
        n_cmp++; if (out_src !== m_q[0].s) begin n_fail++; $display("FAIL rand_src[%0d]: got %0d expected %0d", c, out_src, m_q[0].s); end
      end else begin
        n_cmp++; if (out_last !== 1'b0) begin n_fail++; $display("FAIL rand_idlelast[%0d]: got %b expected 0", c, out_last); end
      end
      model_step();
      @(posedge clk); #1;
    end
    req_valid = '0;
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_round_robin();
    test_len_boundary();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
